// File: rtl/hydra_match_pkg.sv
// hydra_match_pkg: shared types and helpers for the write-side SRAM matcher
package hydra_match_pkg;
  localparam int BEST_SW = 5;
  localparam int BEST_AMT_W = 9;
  localparam int BEST_SPACE_W = 11;
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_HALF = 2'd1,
    MODE_FULL = 2'd2,
    MODE_FULL_ALT = 2'd3
  } match_mode_e;
  typedef enum logic [1:0] {IDLE, SCAN, DONE, FAIL} match_state_e;
  typedef struct packed {
    logic [BEST_SW-1:0] sram;
    logic [BEST_AMT_W-1:0] amt;
    logic [BEST_SPACE_W-1:0] space;
  } best_t;
  function automatic int unsigned group_base(input int unsigned bank, input int unsigned group);
    return bank & ~(group - 1);
  endfunction
endpackage

// File: rtl/sram_scan_gen.sv
// sram_scan_gen: walks the candidate bank set for the selected policy, wrapping per mode
module sram_scan_gen
  import hydra_match_pkg::*;
#(
  parameter int NUM_SRAM = 32,
  parameter int GROUP = 4,
  localparam int SW = $clog2(NUM_SRAM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] home,
  input  logic          start,
  input  logic          advance,
  output logic [SW-1:0] scan_sram,
  output logic [SW:0]   set_size
);
  logic [SW-1:0] off_q, off_d;
  match_mode_e m;
  assign m = match_mode_e'(mode);
  // map the offset onto a bank: fixed home, wrap inside the aligned group, or wrap over all banks
  always_comb begin
    set_size = m == MODE_STATIC ? (SW+1)'(1) : m == MODE_HALF ? (SW+1)'(GROUP) : (SW+1)'(NUM_SRAM);
    scan_sram = m == MODE_STATIC ? home :
                m == MODE_HALF ? SW'(group_base(32'(home), GROUP) + ((32'(home) + 32'(off_q)) & (GROUP - 1))) :
                home + off_q;
    off_d = start ? '0 : advance ? ((32'(off_q) + 1 == 32'(set_size)) ? '0 : off_q + 1'b1) : off_q;
  end
  // offset register, restarted whenever the matcher is not scanning
  always_ff @(posedge clk) begin
    if (!rst_n) off_q <= '0;
    else off_q <= off_d;
  end
endmodule

// File: rtl/wr_sram_matcher_param.sv
// wr_sram_matcher_param: picks a target SRAM bank per packet via sticky reuse or a registered scan
module wr_sram_matcher_param
  import hydra_match_pkg::*;
#(
  parameter int NUM_SRAM = 32,
  parameter int PORT_W = 4,
  parameter int LEN_W = 9,
  parameter int SPACE_W = 11,
  parameter int AMT_W = 9,
  parameter int GROUP = 4,
  parameter int TIMEOUT = 64,
  localparam int SW = $clog2(NUM_SRAM),
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         match_mode,
  input  logic [4:0]         match_threshold,
  input  logic [SW-1:0]      home_sram,
  input  logic               match_enable,
  input  logic [PORT_W-1:0]  new_dest_port,
  input  logic [LEN_W-1:0]   new_length,
  input  logic               viscous,
  output logic               match_suc,
  output logic               match_fail,
  output logic [SW-1:0]      matched_sram,
  output logic               scan_valid,
  output logic [SW-1:0]      scan_sram,
  input  logic               accessible,
  input  logic [SPACE_W-1:0] free_space,
  input  logic [AMT_W-1:0]   packet_amount
);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  match_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic find_q, find_d, find_n, probe_q, hit, better;
  best_t best_q, best_d, best_n;
  logic [SW-1:0] pbank_q, matched_q, matched_d, gen_sram, sticky_sram_q, sticky_sram_d;
  logic [SW:0] set_size;
  logic sticky_valid_q, sticky_valid_d;
  logic [PORT_W-1:0] sticky_port_q, sticky_port_d;
  logic [SPACE_W-1:0] sticky_space_q, sticky_space_d, len_ext;
  logic [31:0] eff_thr;

  assign len_ext = SPACE_W'(new_length);
  assign eff_thr = 32'(match_threshold) < 32'(set_size) ? 32'(match_threshold) : 32'(set_size);
  assign scan_valid = state_q == SCAN;
  assign match_suc = state_q == DONE;
  assign match_fail = state_q == FAIL;
  assign scan_sram = scan_valid ? gen_sram : '0;
  assign matched_sram = matched_q;

  sram_scan_gen #(.NUM_SRAM(NUM_SRAM), .GROUP(GROUP)) u_gen (
    .clk(clk),
    .rst_n(rst_n),
    .mode(match_mode),
    .home(home_sram),
    .start(state_q != SCAN),
    .advance(scan_valid),
    .scan_sram(gen_sram),
    .set_size(set_size)
  );

  // score the response to last cycle's probe against the running best
  always_comb begin
    hit = probe_q && accessible && free_space >= len_ext;
    better = !find_q || packet_amount > AMT_W'(best_q.amt) ||
             (packet_amount == AMT_W'(best_q.amt) && free_space > SPACE_W'(best_q.space));
    find_n = find_q | hit;
    best_n = (hit && better) ? best_t'{sram: BEST_SW'(pbank_q), amt: BEST_AMT_W'(packet_amount),
                                       space: BEST_SPACE_W'(free_space)} : best_q;
  end

  // next state, scan bookkeeping and sticky entry; viscous-low clear is overridden only by a scan load
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    find_d = find_q;
    best_d = best_q;
    matched_d = matched_q;
    sticky_valid_d = viscous ? sticky_valid_q : 1'b0;
    sticky_sram_d = sticky_sram_q;
    sticky_port_d = sticky_port_q;
    sticky_space_d = sticky_space_q;
    case (state_q)
      IDLE: if (match_enable) begin
        if (sticky_valid_q && viscous && new_dest_port == sticky_port_q && sticky_space_q >= len_ext) begin
          state_d = DONE;
          matched_d = sticky_sram_q;
          sticky_space_d = sticky_space_q - len_ext;
        end else begin
          state_d = SCAN;
          tick_d = '0;
          find_d = 1'b0;
          best_d = '0;
        end
      end
      SCAN: if (!match_enable) state_d = IDLE;
      else begin
        find_d = find_n;
        best_d = best_n;
        tick_d = tick_q == TMAX ? tick_q : tick_q + 1'b1;
        if (find_n && 32'(tick_q) >= eff_thr) begin
          state_d = DONE;
          matched_d = SW'(best_n.sram);
          sticky_valid_d = 1'b1;
          sticky_sram_d = SW'(best_n.sram);
          sticky_port_d = new_dest_port;
          sticky_space_d = SPACE_W'(best_n.space) - len_ext;
        end else if (tick_q == TMAX && !find_n) state_d = FAIL;
      end
      DONE: state_d = IDLE;
      FAIL: state_d = IDLE;
    endcase
  end

  // state and pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q <= '0;
      find_q <= 1'b0;
      best_q <= '0;
      probe_q <= 1'b0;
      pbank_q <= '0;
      matched_q <= '0;
      sticky_valid_q <= 1'b0;
      sticky_sram_q <= '0;
      sticky_port_q <= '0;
      sticky_space_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      find_q <= find_d;
      best_q <= best_d;
      probe_q <= scan_valid;
      pbank_q <= scan_sram;
      matched_q <= matched_d;
      sticky_valid_q <= sticky_valid_d;
      sticky_sram_q <= sticky_sram_d;
      sticky_port_q <= sticky_port_d;
      sticky_space_q <= sticky_space_d;
    end
  end
endmodule
